// File: rtl/adc_capture_pkg.sv
// Shared types and width helpers for the ADC lane capture block.
package adc_capture_pkg;

  localparam int unsigned AXIS_DW = 32;
  localparam int unsigned LANE_DW = AXIS_DW / 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONVERT = 3'd1,
    ST_SETUP   = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_EMIT    = 3'd4
  } state_e;

  // One AXIS beat: odd lane in the upper half, even lane in the lower half.
  typedef struct packed {
    logic [LANE_DW-1:0] hi;
    logic [LANE_DW-1:0] lo;
  } axis_word_t;

  // Bits needed for a counter that runs 0..n-1 (never less than one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adc_spi_sclk_gen.sv
// ADC serial clock divider: CLK_DIV cycles low then CLK_DIV cycles high per bit,
// SAMPLE_BITS bits per burst, with capture/done strobes for the parent FSM.
module adc_spi_sclk_gen
  import adc_capture_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned SAMPLE_BITS = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  output logic o_sclk,
  output logic o_capture_c,
  output logic o_done_c
);

  localparam int unsigned DIV_W = cnt_w(CLK_DIV);
  localparam int unsigned BIT_W = cnt_w(SAMPLE_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SAMPLE_BITS - 1);

  logic             r_active;
  logic             r_sclk;
  logic [DIV_W-1:0] r_div_cnt;
  logic [BIT_W-1:0] r_bit_cnt;
  logic             w_phase_end;

  assign w_phase_end = r_active && (r_div_cnt == DIV_LAST);
  // High in the cycle whose closing edge drives sclk 0->1.
  assign o_capture_c = w_phase_end && !r_sclk;
  // High in the cycle whose closing edge ends the last high phase.
  assign o_done_c    = w_phase_end && r_sclk && (r_bit_cnt == BIT_LAST);
  assign o_sclk      = r_sclk;

  // Phase/bit counters and the divided clock itself.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active  <= 1'b0;
      r_sclk    <= 1'b0;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
    end else if (i_start) begin
      r_active  <= 1'b1;
      r_sclk    <= 1'b0;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
    end else if (r_active) begin
      if (w_phase_end) begin
        r_div_cnt <= '0;
        r_sclk    <= !r_sclk;
        if (r_sclk) begin
          if (r_bit_cnt == BIT_LAST) begin
            r_active <= 1'b0;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_lane_capture.sv
// Multi-lane ADC readout: convert pulse, parallel SPI shift-in, then AXIS emit
// of lane pairs packed into 32-bit words with per-frame tlast.
module adc_lane_capture
  import adc_capture_pkg::*;
#(
  parameter int unsigned N_LANES     = 8,
  parameter int unsigned SAMPLE_BITS = 16,
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned CNV_CYCLES  = 40,
  parameter int unsigned FRAME_LEN   = 64
) (
  input  logic                 m00_axis_aclk,
  input  logic                 m00_axis_aresetn,
  input  logic                 enable,
  input  logic                 sample,
  input  logic [N_LANES-1:0]   ADC_SPI,
  output logic                 ADC_cnv,
  output logic                 ADC_cs_n,
  output logic                 ADC_SPI_clk,
  output logic                 m00_axis_tvalid,
  output logic [AXIS_DW-1:0]   m00_axis_tdata,
  output logic [3:0]           m00_axis_tstrb,
  output logic                 m00_axis_tlast,
  input  logic                 m00_axis_tready,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  localparam int unsigned N_WORDS = N_LANES / 2;
  localparam int unsigned CNV_W   = cnt_w(CNV_CYCLES);
  localparam int unsigned FRM_W   = cnt_w(FRAME_LEN);
  localparam int unsigned IDX_W   = cnt_w(N_WORDS);
  localparam logic [CNV_W-1:0] CNV_LAST = CNV_W'(CNV_CYCLES - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_WORDS - 1);

  state_e           r_state, w_state_next;
  logic [CNV_W-1:0] r_cnv_cnt, w_cnv_cnt_next;
  logic [IDX_W-1:0] r_word_idx, w_word_idx_next;
  logic [FRM_W-1:0] r_frame_cnt, w_frame_cnt_next;
  logic             r_cnv, w_cnv_next;
  logic             r_cs_n, w_cs_n_next;
  logic             r_tvalid, w_tvalid_next;
  logic             r_tlast, w_tlast_next;
  logic [3:0]       r_tstrb, w_tstrb_next;
  axis_word_t       r_tdata, w_tdata_next;
  logic             r_overrun, w_overrun_next;

  logic             w_load;
  logic [IDX_W-1:0] w_load_idx;

  logic [SAMPLE_BITS-1:0] r_lane [N_LANES];
  axis_word_t             w_words [N_WORDS];

  logic w_sclk;
  logic w_sclk_start_c;
  logic w_capture_c;
  logic w_done_c;

  assign w_sclk_start_c = (r_state == ST_SETUP);

  adc_spi_sclk_gen #(
    .CLK_DIV     (CLK_DIV),
    .SAMPLE_BITS (SAMPLE_BITS)
  ) u_sclk_gen (
    .i_clk       (m00_axis_aclk),
    .i_rst_n     (m00_axis_aresetn),
    .i_start     (w_sclk_start_c),
    .o_sclk      (w_sclk),
    .o_capture_c (w_capture_c),
    .o_done_c    (w_done_c)
  );

  assign ADC_cnv         = r_cnv;
  assign ADC_cs_n        = r_cs_n;
  assign ADC_SPI_clk     = w_sclk;
  assign m00_axis_tvalid = r_tvalid;
  assign m00_axis_tdata  = r_tdata;
  assign m00_axis_tstrb  = r_tstrb;
  assign m00_axis_tlast  = r_tlast;
  assign overrun         = r_overrun;

  // Shift each lane MSB first on the edge that raises the serial clock.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      for (int i = 0; i < N_LANES; i++) r_lane[i] <= '0;
    end else if ((r_state == ST_SHIFT) && w_capture_c) begin
      for (int i = 0; i < N_LANES; i++) begin
        r_lane[i] <= SAMPLE_BITS'({r_lane[i], ADC_SPI[i]});
      end
    end
  end

  // Pair lanes into stream words, zero-extending each lane to 16 bits.
  always_comb begin
    for (int k = 0; k < N_WORDS; k++) begin
      w_words[k].lo = LANE_DW'(r_lane[2*k]);
      w_words[k].hi = LANE_DW'(r_lane[2*k+1]);
    end
  end

  // FSM state register.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) r_state <= ST_IDLE;
    else                   r_state <= w_state_next;
  end

  // Next-state and next-value logic for every registered output and counter.
  always_comb begin
    w_state_next     = r_state;
    w_cnv_cnt_next   = r_cnv_cnt;
    w_word_idx_next  = r_word_idx;
    w_frame_cnt_next = r_frame_cnt;
    w_cnv_next       = r_cnv;
    w_cs_n_next      = r_cs_n;
    w_tvalid_next    = r_tvalid;
    w_tlast_next     = r_tlast;
    w_tdata_next     = r_tdata;
    w_overrun_next   = r_overrun;
    w_load           = 1'b0;
    w_load_idx       = r_word_idx;

    // Strobes outside IDLE are dropped and flagged; a fresh drop beats a clear.
    if (sample && (r_state != ST_IDLE)) w_overrun_next = 1'b1;
    else if (overrun_clr)               w_overrun_next = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (sample && enable) begin
          w_state_next   = ST_CONVERT;
          w_cnv_next     = 1'b1;
          w_cnv_cnt_next = '0;
        end
      end
      ST_CONVERT: begin
        if (r_cnv_cnt == CNV_LAST) begin
          w_state_next = ST_SETUP;
          w_cnv_next   = 1'b0;
          w_cs_n_next  = 1'b0;
        end else begin
          w_cnv_cnt_next = r_cnv_cnt + 1'b1;
        end
      end
      ST_SETUP: begin
        w_state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_done_c) begin
          w_state_next    = ST_EMIT;
          w_cs_n_next     = 1'b1;
          w_word_idx_next = '0;
        end
      end
      ST_EMIT: begin
        if (!r_tvalid) begin
          w_tvalid_next = 1'b1;
          w_load        = 1'b1;
          w_load_idx    = '0;
        end else if (m00_axis_tready) begin
          if (r_word_idx == IDX_LAST) begin
            w_state_next  = ST_IDLE;
            w_tvalid_next = 1'b0;
            w_tlast_next  = 1'b0;
            w_tdata_next  = '0;
            w_frame_cnt_next = (r_frame_cnt == FRM_LAST) ? '0 : r_frame_cnt + 1'b1;
          end else begin
            w_word_idx_next = r_word_idx + 1'b1;
            w_load          = 1'b1;
            w_load_idx      = r_word_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (w_load) begin
      w_tdata_next = w_words[w_load_idx];
      w_tlast_next = (w_load_idx == IDX_LAST) && (r_frame_cnt == FRM_LAST);
    end

    w_tstrb_next = w_tvalid_next ? 4'hF : 4'h0;
  end

  // Datapath and output registers.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      r_cnv_cnt   <= '0;
      r_word_idx  <= '0;
      r_frame_cnt <= '0;
      r_cnv       <= 1'b0;
      r_cs_n      <= 1'b1;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_tstrb     <= 4'h0;
      r_tdata     <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_cnv_cnt   <= w_cnv_cnt_next;
      r_word_idx  <= w_word_idx_next;
      r_frame_cnt <= w_frame_cnt_next;
      r_cnv       <= w_cnv_next;
      r_cs_n      <= w_cs_n_next;
      r_tvalid    <= w_tvalid_next;
      r_tlast     <= w_tlast_next;
      r_tstrb     <= w_tstrb_next;
      r_tdata     <= w_tdata_next;
      r_overrun   <= w_overrun_next;
    end
  end

endmodule

// File: tb/tb_adc_lane_capture.sv
// Self-checking bench for adc_lane_capture: bit-level ADC lane model driven
// from the serial clock, and a scoreboard of expected stream words.
module tb_adc_lane_capture;

  localparam int N_LANES = 8;
  localparam int SB      = 16;
  localparam int CLK_DIV = 2;
  localparam int CNV     = 40;
  localparam int FL      = 3;
  localparam int N_WORDS = N_LANES / 2;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b0;
  logic               sample = 1'b0;
  logic               tready = 1'b1;
  logic               overrun_clr = 1'b0;
  logic [N_LANES-1:0] adc_spi;
  logic               ADC_cnv, ADC_cs_n, ADC_SPI_clk;
  logic               tvalid, tlast, overrun;
  logic [31:0]        tdata;
  logic [3:0]         tstrb;

  logic [15:0] lane_val [N_LANES];
  int          bc = 0;
  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          m_conv = 0;
  int          n_xfer = 0;
  int          tlast_cnt = 0;
  int          tlast_pos = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  always #5 clk = ~clk;

  adc_lane_capture #(
    .N_LANES(N_LANES), .SAMPLE_BITS(SB), .CLK_DIV(CLK_DIV),
    .CNV_CYCLES(CNV), .FRAME_LEN(FL)
  ) dut (
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (rst_n),
    .enable           (enable),
    .sample           (sample),
    .ADC_SPI          (adc_spi),
    .ADC_cnv          (ADC_cnv),
    .ADC_cs_n         (ADC_cs_n),
    .ADC_SPI_clk      (ADC_SPI_clk),
    .m00_axis_tvalid  (tvalid),
    .m00_axis_tdata   (tdata),
    .m00_axis_tstrb   (tstrb),
    .m00_axis_tlast   (tlast),
    .m00_axis_tready  (tready),
    .overrun          (overrun),
    .overrun_clr      (overrun_clr)
  );

  // ADC model: present the next bit after every serial clock rise.
  always @(posedge ADC_SPI_clk or posedge ADC_cs_n) begin
    if (ADC_cs_n) bc <= 0;
    else          bc <= bc + 1;
  end

  always_comb begin
    for (int i = 0; i < N_LANES; i++) begin
      adc_spi[i] = (bc < SB) ? lane_val[i][4'(SB - 1 - bc)] : 1'b0;
    end
  end

  // Expected words for one conversion of the current lane values.
  task automatic push_conv();
    exp_t e;
    for (int k = 0; k < N_WORDS; k++) begin
      e.data = {lane_val[2*k+1], lane_val[2*k]};
      e.last = (k == N_WORDS - 1) && (m_conv == FL - 1);
      q.push_back(e);
    end
    m_conv = (m_conv + 1) % FL;
  endtask

  task automatic run_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else if (tvalid) begin
        checks++;
        if (tstrb !== 4'hF) begin
          errors++;
          $display("FAIL tstrb: got %h want f", tstrb);
        end
        if (prev_stall) begin
          checks++;
          if (tdata !== prev_data) begin
            errors++;
            $display("FAIL hold_stable: got %h want %h", tdata, prev_data);
          end
        end
        if (tready) begin
          prev_stall = 1'b0;
          n_xfer++;
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got %h want none", tdata);
          end else begin
            e = q.pop_front();
            if (tdata !== e.data || tlast !== e.last) begin
              errors++;
              $display("FAIL word%0d: got %h/%b want %h/%b", n_xfer, tdata, tlast, e.data, e.last);
            end
          end
          if (tlast) begin
            tlast_cnt++;
            tlast_pos = n_xfer;
          end
        end else begin
          prev_stall = 1'b1;
          prev_data  = tdata;
        end
      end else begin
        if (prev_stall) begin
          checks++;
          errors++;
          $display("FAIL tvalid_dropped: got 0 want 1");
        end
        prev_stall = 1'b0;
      end
    end
  endtask

  task automatic start_conv(input bit push);
    if (push) push_conv();
    sample = 1'b1;
    @(posedge clk); #1;
    sample = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(q.size() == 0 && !tvalid && ADC_cs_n && !ADC_cnv) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_idle: got timeout after %0d cycles want idle, %0d words pending", name, n, q.size());
      q.delete();
    end
  endtask

  task automatic wait_sig(input string name, input bit want_tvalid, input int budget);
    int n = 0;
    while (!(want_tvalid ? tvalid : ADC_SPI_clk) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_wait: got timeout want event", name);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    m_conv    = 0;
    q.delete();
    n_xfer    = 0;
    tlast_cnt = 0;
    tlast_pos = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int bad = 0;
    rst_n = 1'b0;
    for (int c = 0; c < 20; c++) begin
      sample = ~sample;
      @(posedge clk); #1;
      if ({ADC_cnv, ADC_cs_n, ADC_SPI_clk, tvalid, tlast, overrun} !== 6'b010000) bad++;
    end
    checks++;
    if (bad != 0 || tdata !== 32'h0 || tstrb !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %0d bad cycles, tdata %h tstrb %h want 0", bad, tdata, tstrb);
    end
    sample = 1'b0;
    rst_n  = 1'b1;
    enable = 1'b1;
    bad    = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (ADC_cnv || !ADC_cs_n || tvalid || overrun) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_quiet: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_single();
    int n = 0, cnv_hi = 0, cnv_first = -1, rises = 0, first_rise = -1, last_rise = -1, lat = -1;
    logic prev_sclk = 1'b0;
    for (int i = 0; i < N_LANES; i++) lane_val[i] = 16'(32'h1111 * (i + 1));
    push_conv();
    sample = 1'b1;
    while (lat < 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
      sample = 1'b0;
      if (ADC_cnv) begin
        cnv_hi++;
        if (cnv_first < 0) cnv_first = n;
      end
      if (ADC_SPI_clk && !prev_sclk) begin
        rises++;
        if (first_rise < 0) first_rise = n;
        last_rise = n;
      end
      prev_sclk = ADC_SPI_clk;
      if (tvalid) lat = n;
    end
    checks++;
    if (cnv_first != 1) begin
      errors++;
      $display("FAIL cnv_start: got cycle %0d want 1", cnv_first);
    end
    checks++;
    if (cnv_hi != CNV) begin
      errors++;
      $display("FAIL cnv_width: got %0d want %0d", cnv_hi, CNV);
    end
    checks++;
    if (rises != SB || (last_rise - first_rise) != (SB - 1) * 2 * CLK_DIV) begin
      errors++;
      $display("FAIL sclk_periods: got %0d rises span %0d want %0d span %0d",
               rises, last_rise - first_rise, SB, (SB - 1) * 2 * CLK_DIV);
    end
    checks++;
    if (lat != 1 + CNV + 1 + SB * 2 * CLK_DIV + 1) begin
      errors++;
      $display("FAIL latency: got %0d want %0d", lat, 1 + CNV + 1 + SB * 2 * CLK_DIV + 1);
    end
    checks++;
    if (tdata !== 32'h22221111) begin
      errors++;
      $display("FAIL first_word: got %h want 22221111", tdata);
    end
    wait_idle("single", 50);
  endtask

  task automatic test_backpressure();
    logic [31:0] exp1;
    for (int i = 0; i < N_LANES; i++) lane_val[i] = 16'($urandom);
    exp1 = {lane_val[3], lane_val[2]};
    start_conv(1'b1);
    wait_sig("bp", 1'b1, 300);
    @(posedge clk); #1;
    tready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (!tvalid || tdata !== exp1) begin
        errors++;
        $display("FAIL bp_hold%0d: got %b/%h want 1/%h", c, tvalid, tdata, exp1);
      end
    end
    tready = 1'b1;
    wait_idle("bp", 50);
  endtask

  task automatic test_framing();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < N_LANES; i++) lane_val[i] = 16'($urandom);
      start_conv(1'b1);
      wait_idle("frame", 200);
    end
    checks++;
    if (tlast_cnt != 1 || tlast_pos != FL * N_WORDS) begin
      errors++;
      $display("FAIL frame_tlast: got %0d at word %0d want 1 at word %0d", tlast_cnt, tlast_pos, FL * N_WORDS);
    end
  endtask

  task automatic test_overrun();
    int cnv_seen = 0;
    enable = 1'b0;
    sample = 1'b1;
    @(posedge clk); #1;
    sample = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (ADC_cnv || !ADC_cs_n || overrun) begin
      errors++;
      $display("FAIL disabled_drop: got cnv %b cs_n %b ovr %b want 0 1 0", ADC_cnv, ADC_cs_n, overrun);
    end
    enable = 1'b1;
    for (int i = 0; i < N_LANES; i++) lane_val[i] = 16'($urandom);
    start_conv(1'b1);
    wait_sig("ovr", 1'b0, 200);
    sample = 1'b1;
    @(posedge clk); #1;
    sample = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set: got %b want 1", overrun);
    end
    sample = 1'b1;
    overrun_clr = 1'b1;
    @(posedge clk); #1;
    sample = 1'b0;
    overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set_wins: got %b want 1", overrun);
    end
    overrun_clr = 1'b1;
    @(posedge clk); #1;
    overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clr: got %b want 0", overrun);
    end
    wait_idle("ovr", 200);
    repeat (120) begin
      @(posedge clk); #1;
      if (ADC_cnv) cnv_seen++;
    end
    checks++;
    if (cnv_seen != 0) begin
      errors++;
      $display("FAIL ovr_no_extra: got %0d cnv cycles want 0", cnv_seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_last;
    for (int i = 0; i < N_LANES; i++) lane_val[i] = 16'($urandom);
    exp_last = {lane_val[N_LANES-1], lane_val[N_LANES-2]};
    start_conv(1'b1);
    wait_sig("b2b", 1'b1, 300);
    repeat (N_WORDS - 1) begin
      @(posedge clk); #1;
    end
    checks++;
    if (!tvalid || tdata !== exp_last) begin
      errors++;
      $display("FAIL b2b_last_word: got %b/%h want 1/%h", tvalid, tdata, exp_last);
    end
    sample = 1'b1;
    @(posedge clk); #1;
    sample = 1'b0;
    checks++;
    if (overrun !== 1'b1 || tvalid !== 1'b0 || ADC_cnv !== 1'b0) begin
      errors++;
      $display("FAIL b2b_emit_drop: got ovr %b tvalid %b cnv %b want 1 0 0", overrun, tvalid, ADC_cnv);
    end
    start_conv(1'b1);
    checks++;
    if (ADC_cnv !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got cnv %b want 1", ADC_cnv);
    end
    wait_idle("b2b", 200);
    overrun_clr = 1'b1;
    @(posedge clk); #1;
    overrun_clr = 1'b0;
  endtask

  task automatic test_abort();
    for (int i = 0; i < N_LANES; i++) lane_val[i] = 16'($urandom);
    start_conv(1'b0);
    wait_sig("abort", 1'b0, 200);
    rst_n = 1'b0;
    #1;
    checks++;
    if (ADC_cs_n !== 1'b1 || ADC_SPI_clk !== 1'b0 || tvalid !== 1'b0 || ADC_cnv !== 1'b0) begin
      errors++;
      $display("FAIL abort_async: got cs_n %b sclk %b tvalid %b cnv %b want 1 0 0 0",
               ADC_cs_n, ADC_SPI_clk, tvalid, ADC_cnv);
    end
    @(posedge clk); #1;
    do_reset();
    for (int c = 0; c < FL; c++) begin
      for (int i = 0; i < N_LANES; i++) lane_val[i] = 16'($urandom);
      start_conv(1'b1);
      wait_idle("abort", 200);
    end
    checks++;
    if (tlast_cnt != 1 || tlast_pos != FL * N_WORDS) begin
      errors++;
      $display("FAIL abort_frame_restart: got %0d at word %0d want 1 at word %0d", tlast_cnt, tlast_pos, FL * N_WORDS);
    end
  endtask

  initial begin
    for (int i = 0; i < N_LANES; i++) lane_val[i] = '0;
    fork
      run_monitor();
    join_none
    test_reset();
    test_single();
    test_backpressure();
    test_framing();
    test_overrun();
    test_back_to_back();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/adc_lane_capture.md
Name: adc_lane_capture

Overview:
Multi-lane ADC readout stage that sits directly upstream of the AXI-Stream master output of the ADC/DAC test core.
- On each `sample` strobe it runs one conversion cycle: pulses ADC_cnv, then clocks SAMPLE_BITS bits out of N_LANES parallel SPI data lanes.
- It packs the lane results two per 32-bit word and emits them on m00_axis with tlast at frame boundaries.
- Single clock domain; ADC_SPI_clk is generated by dividing the AXIS clock.

Parameters:
N_LANES, 8, number of parallel ADC SPI data lanes; must be even.
SAMPLE_BITS, 16, bits per lane per conversion; legal range 1..16.
CLK_DIV, 2, ADC_SPI_clk half-period in aclk cycles; must be ≥1.
CNV_CYCLES, 40, ADC_cnv high time in aclk cycles; must be ≥1.
FRAME_LEN, 64, conversions per AXIS packet; must be ≥1.

Ports:
m00_axis_aclk  in  1  block clock; all logic on rising edge
m00_axis_aresetn  in  1  asynchronous active-low reset
enable  in  1  level; 0 blocks new conversions from starting
sample  in  1  single-cycle conversion request strobe
ADC_SPI  in  N_LANES  serial data from ADC lanes, MSB first
ADC_cnv  out  1  ADC conversion start
ADC_cs_n  out  1  ADC chip select, active low
ADC_SPI_clk  out  1  ADC serial clock, idles low
m00_axis_tvalid  out  1  stream word valid
m00_axis_tdata  out  32  {lane 2k+1, lane 2k}, each zero-extended to 16 bits
m00_axis_tstrb  out  4  constant 4'hF while tvalid, else 0
m00_axis_tlast  out  1  last word of a frame
m00_axis_tready  in  1  downstream ready
overrun  out  1  sticky: a `sample` strobe was dropped
overrun_clr  in  1  clears `overrun`

Behaviour:
- Reset values (async on aresetn=0):
  - All outputs 0, except ADC_cs_n=1.
  - State returns to IDLE; frame counter and shift registers are cleared.
  - Reset mid-conversion aborts it; no partial word is emitted.
- IDLE:
  - `sample`=1 and `enable`=1 → CONVERT on the next edge.
  - ADC_cnv=1 starting the cycle after the strobe.
- CONVERT:
  - ADC_cnv held high for exactly CNV_CYCLES cycles.
  - Then ADC_cnv=0, ADC_cs_n=0, and the block waits one setup cycle before entering SHIFT.
- SHIFT:
  - Each bit is one period: ADC_SPI_clk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - ADC_SPI[i] is captured into lane register i on the aclk edge where ADC_SPI_clk is driven 0→1.
  - Capture is MSB first, SAMPLE_BITS bits.
  - After the last high phase: ADC_SPI_clk=0, ADC_cs_n=1 on the next cycle, then → EMIT.
- EMIT:
  - Outputs N_LANES/2 words, in order k=0..N_LANES/2-1.
  - tdata[15:0] = lane 2k; tdata[31:16] = lane 2k+1.
  - Each word is held stable with tvalid=1 until tready=1 (AXIS rule: a transfer occurs on tvalid&tready).
  - No tvalid bubbles between words when tready stays 1.
  - After the final word transfers → IDLE.
- Latency: strobe to first tvalid = 1 + CNV_CYCLES + 1 + SAMPLE_BITS·2·CLK_DIV + 1 cycles.
  - Defaults: 1+40+1+64+1 = 107 cycles.
- Framing:
  - A conversion counter runs 0..FRAME_LEN-1.
  - tlast=1 only on the final word of conversion FRAME_LEN-1; the counter then wraps to 0.
- Overrun:
  - `sample`=1 outside IDLE is ignored and sets `overrun`.
  - `overrun_clr` clears it one cycle later.
  - If set and clear occur in the same cycle, set wins.
  - `sample` in IDLE with enable=0 is dropped silently and does not set overrun.
- enable deasserted mid-operation: the current conversion completes, including EMIT; the frame counter is not reset.
- A `sample` arriving in the same cycle EMIT returns to IDLE counts as an overrun. IDLE must be registered before a new strobe is accepted.

Decomposition:
- Shared package adc_capture_pkg holds:
  - State encoding constants: IDLE, CONVERT, SETUP, SHIFT, EMIT.
  - Width helper functions for the counters (clog2 of CLK_DIV, SAMPLE_BITS, FRAME_LEN).
  - The fixed AXIS data width of 32.
- One sub-module, adc_spi_sclk_gen:
  - Divider that produces ADC_SPI_clk.
  - Produces a single-cycle `capture` pulse on each 0→1 transition.
  - Produces a `done` pulse after SAMPLE_BITS periods.

Test Plan:
- Reset/idle: hold aresetn=0 for 20 cycles with sample toggling → all outputs 0, ADC_cs_n=1, no tvalid; release reset and check nothing happens until `sample`.
- Single conversion, defaults: drive lanes with patterns 0x1111·(i+1) and tready=1 → ADC_cnv high exactly 40 cycles, 16 SCLK periods of 4 cycles, first tvalid at cycle 107; words 0x22221111, 0x44443333, 0x66665555, 0x88887777; tstrb=F; tlast=0.
- Backpressure: same run, tready low for 5 cycles on word 1 → tdata/tvalid stay stable; all 4 words delivered in order with none lost or duplicated.
- Framing: FRAME_LEN=3, 4 conversions → tlast only on word 3 of conversion 3 (12th word); conversion 4 word 3 has tlast=0.
- Overrun: strobe `sample` during SHIFT → overrun=1 and no extra conversion; overrun_clr and a new drop in the same cycle → overrun stays 1; clr alone → 0.
- Abort: assert aresetn=0 mid-SHIFT → ADC_cs_n=1 and SCLK=0 immediately; after release, the next strobe yields a clean conversion and the frame count restarts at 0.
